// File: rtl/coin_level_loader_if.sv
// Coin bank bus: level requests, coin ROM port, and per-slot positions/flags.
// master = loader side, slave = game FSM / ROM / coin-instance side.
interface coin_level_loader_if #(
  parameter int N_COINS = 4,
  parameter int AW      = 5
);
  localparam int CW = $clog2(N_COINS + 1);

  logic                    load_level;
  logic [3:0]              level;
  logic                    player_dead;
  logic [AW-1:0]           rom_addr;
  logic [19:0]             rom_data;
  logic [N_COINS-1:0]      collected;
  logic [10*N_COINS-1:0]   coin_x;
  logic [10*N_COINS-1:0]   coin_y;
  logic                    refresh;
  logic                    busy;
  logic [CW-1:0]           coins_total;
  logic [CW-1:0]           coins_left;
  logic                    all_collected;

  modport master (
    input  load_level, level, player_dead, rom_data, collected,
    output rom_addr, coin_x, coin_y, refresh, busy,
           coins_total, coins_left, all_collected
  );

  modport slave (
    output load_level, level, player_dead, rom_data, collected,
    input  rom_addr, coin_x, coin_y, refresh, busy,
           coins_total, coins_left, all_collected
  );
endinterface

// File: rtl/coin_level_loader.sv
// Loads a level's coin positions from a synchronous ROM (2 cycles/slot + 1 rearm cycle),
// holds coins in refresh while placing them, and tracks outstanding coins for level completion.
module coin_level_loader #(
  parameter int N_COINS = 4,
  parameter int LEVELS  = 8,
  parameter int AW      = 5
) (
  input  logic               frame_clk,
  input  logic               Reset,
  coin_level_loader_if.master bus
);
  localparam int CW = $clog2(N_COINS + 1);
  localparam int IW = (N_COINS > 1) ? $clog2(N_COINS) : 1;
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, REARM, ACTIVE} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   lvl;
  logic [LW-1:0]   lvl_clamped;
  logic [IW-1:0]   idx;
  logic            last_slot;
  logic            load_start;
  logic [9:0]      pos_x [N_COINS];
  logic [9:0]      pos_y [N_COINS];
  logic [CW-1:0]   left_cnt;

  assign lvl_clamped = (int'(bus.level) >= LEVELS) ? LW'(LEVELS - 1) : LW'(bus.level);
  assign last_slot   = (idx == IW'(N_COINS - 1));
  assign load_start  = ((state == IDLE) || (state == ACTIVE)) && (state_nxt == FETCH);
  assign bus.rom_addr = AW'(int'(lvl) * N_COINS + int'(idx));

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load_level) state_nxt = FETCH;
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = last_slot ? REARM : FETCH;
      REARM:   state_nxt = ACTIVE;
      ACTIVE: begin
        if (bus.load_level)       state_nxt = FETCH;
        else if (bus.player_dead) state_nxt = REARM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == FETCH) || (state == CAPTURE) || (state == REARM);
  end

  // ROM data for slot idx arrives in CAPTURE, one cycle after FETCH presented the address.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      lvl             <= '0;
      idx             <= '0;
      bus.coins_total <= '0;
      bus.refresh     <= 1'b0;
      bus.all_collected <= 1'b0;
      for (int i = 0; i < N_COINS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else begin
      bus.refresh <= (state_nxt == FETCH) || (state_nxt == CAPTURE) || (state_nxt == REARM);
      bus.all_collected <= (state == ACTIVE) && (state_nxt == ACTIVE) &&
                           (bus.all_collected ||
                            ((left_cnt == '0) && (bus.coins_total != '0)));
      if (load_start) begin
        lvl             <= lvl_clamped;
        idx             <= '0;
        bus.coins_total <= '0;
      end else if (state == CAPTURE) begin
        pos_x[idx] <= bus.rom_data[19:10];
        pos_y[idx] <= bus.rom_data[9:0];
        if (bus.rom_data != '0) bus.coins_total <= bus.coins_total + CW'(1);
        if (!last_slot) idx <= idx + IW'(1);
      end
    end
  end

  // Empty slots sit at (0,0) and are never counted, whatever their collected flag says.
  always_comb begin
    left_cnt = '0;
    for (int i = 0; i < N_COINS; i++) begin
      if (({pos_x[i], pos_y[i]} != 20'd0) && !bus.collected[i]) left_cnt = left_cnt + CW'(1);
    end
  end
  assign bus.coins_left = left_cnt;

  for (genvar g = 0; g < N_COINS; g++) begin : g_pack
    assign bus.coin_x[10*g +: 10] = pos_x[g];
    assign bus.coin_y[10*g +: 10] = pos_y[g];
  end
endmodule

// File: tb/tb_coin_level_loader.sv
// Directed bench for coin_level_loader: behavioural coin ROM, hand-computed expectations.
module tb_coin_level_loader;
  logic frame_clk = 1'b0;
  logic Reset;
  logic [19:0] rom [32];
  int n_checks = 0;
  int n_fail   = 0;

  coin_level_loader_if #(.N_COINS(4), .AW(5)) bus ();

  coin_level_loader #(.N_COINS(4), .LEVELS(8), .AW(5)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  always @(posedge frame_clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Request a load and follow the 9 busy cycles; optionally poke load_level mid-load.
  task automatic do_load(input logic [3:0] lv, input int base, input bit poke);
    bus.level      = lv;
    bus.load_level = 1'b1;
    step();
    bus.load_level  = 1'b0;
    bus.player_dead = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("busy_during_load", bus.busy, 1);
      chk("refresh_during_load", bus.refresh, 1);
      if ((i < 8) && (i % 2 == 0)) chk("rom_addr_fetch", bus.rom_addr, base + i / 2);
      bus.load_level = (poke && (i == 3));
      step();
    end
    bus.load_level = 1'b0;
    chk("busy_after_load", bus.busy, 0);
    chk("refresh_after_load", bus.refresh, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 20'd0;
    rom[4]  = {10'd10,   10'd20};
    rom[5]  = {10'd0,    10'd0};
    rom[6]  = {10'd30,   10'd40};
    rom[7]  = {10'd1023, 10'd1023};
    rom[8]  = {10'd100,  10'd50};
    rom[9]  = {10'd200,  10'd60};
    rom[10] = {10'd300,  10'd70};
    rom[11] = {10'd0,    10'd0};
    rom[28] = {10'd5,    10'd6};
    rom[29] = {10'd7,    10'd8};
    rom[30] = {10'd0,    10'd0};
    rom[31] = {10'd9,    10'd10};

    Reset           = 1'b1;
    bus.load_level  = 1'b0;
    bus.level       = 4'd0;
    bus.player_dead = 1'b0;
    bus.collected   = 4'b1000;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_refresh", bus.refresh, 0);
    chk("rst_total", bus.coins_total, 0);
    chk("rst_all_collected", bus.all_collected, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_coin_x", bus.coin_x, 0);
    chk("rst_coin_y", bus.coin_y, 0);
    Reset = 1'b0;
    step();
    bus.player_dead = 1'b1;
    step();
    bus.player_dead = 1'b0;
    chk("idle_ignores_dead", bus.busy, 0);

    // Level 2
    do_load(4'd2, 8, 1'b0);
    chk("l2_coin_x", bus.coin_x, {10'd0, 10'd300, 10'd200, 10'd100});
    chk("l2_coin_y", bus.coin_y, {10'd0, 10'd70, 10'd60, 10'd50});
    chk("l2_total", bus.coins_total, 3);
    chk("l2_left", bus.coins_left, 3);
    chk("l2_allc", bus.all_collected, 0);

    bus.collected = 4'b1001;
    #1;
    chk("c1001_left", bus.coins_left, 2);
    step();
    chk("c1001_allc", bus.all_collected, 0);
    bus.collected = 4'b1111;
    #1;
    chk("c1111_left", bus.coins_left, 0);
    chk("c1111_allc_same_cycle", bus.all_collected, 0);
    step();
    chk("c1111_allc_next", bus.all_collected, 1);
    step();
    chk("c1111_allc_held", bus.all_collected, 1);

    // Player death: one REARM cycle, positions kept
    bus.collected = 4'b0011;
    #1;
    chk("c0011_left", bus.coins_left, 1);
    bus.player_dead = 1'b1;
    step();
    bus.player_dead = 1'b0;
    chk("rearm_refresh", bus.refresh, 1);
    chk("rearm_busy", bus.busy, 1);
    chk("rearm_allc", bus.all_collected, 0);
    chk("rearm_rom_addr", bus.rom_addr, 11);
    chk("rearm_coin_x", bus.coin_x, {10'd0, 10'd300, 10'd200, 10'd100});
    step();
    chk("post_rearm_refresh", bus.refresh, 0);
    chk("post_rearm_busy", bus.busy, 0);
    chk("post_rearm_allc", bus.all_collected, 0);
    chk("post_rearm_coin_y", bus.coin_y, {10'd0, 10'd70, 10'd60, 10'd50});

    // load_level beats player_dead
    bus.collected   = 4'b0000;
    bus.player_dead = 1'b1;
    do_load(4'd1, 4, 1'b0);
    chk("l1_coin_x", bus.coin_x, {10'd1023, 10'd30, 10'd0, 10'd10});
    chk("l1_coin_y", bus.coin_y, {10'd1023, 10'd40, 10'd0, 10'd20});
    chk("l1_total", bus.coins_total, 3);
    chk("l1_left", bus.coins_left, 3);

    // Reset during third CAPTURE
    bus.level      = 4'd2;
    bus.load_level = 1'b1;
    step();
    bus.load_level = 1'b0;
    repeat (5) step();
    chk("midload_busy", bus.busy, 1);
    Reset = 1'b1;
    #1;
    chk("async_rst_coin_x", bus.coin_x, 0);
    chk("async_rst_coin_y", bus.coin_y, 0);
    chk("async_rst_refresh", bus.refresh, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_total", bus.coins_total, 0);
    chk("async_rst_rom_addr", bus.rom_addr, 0);
    chk("async_rst_left", bus.coins_left, 0);
    #2;
    Reset = 1'b0;
    step();

    // Level 15 clamps to 7; extra load_level during busy ignored
    do_load(4'd15, 28, 1'b1);
    chk("l15_coin_x", bus.coin_x, {10'd9, 10'd0, 10'd7, 10'd5});
    chk("l15_coin_y", bus.coin_y, {10'd10, 10'd0, 10'd8, 10'd6});
    chk("l15_total", bus.coins_total, 3);

    // Coin-free level
    bus.collected = 4'b1111;
    do_load(4'd0, 0, 1'b0);
    chk("l0_total", bus.coins_total, 0);
    chk("l0_left", bus.coins_left, 0);
    chk("l0_coin_x", bus.coin_x, 0);
    repeat (3) step();
    chk("l0_allc_never", bus.all_collected, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/coin_level_loader.md
Name: coin_level_loader

Overview:
- Drives the position inputs and the refresh strobe of a bank of N_COINS coin instances, and consumes their collected flags. It is the producer/consumer end of the coin interface.
- On a level-load request it reads the coin table for that level from a synchronous coin ROM, places every coin, and holds the coins cleared while they are placed.
- While the level is in play it counts the coins still outstanding and reports level completion to the game FSM.
- On player death it re-arms all coins without reloading.

Parameters:
- N_COINS, 4, coin slots per level (coin instances driven).
- LEVELS, 8, number of levels held in the coin ROM.
- AW, 5, coin ROM address width; must satisfy 2^AW >= LEVELS*N_COINS.

Ports:
- frame_clk  in  1  frame clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- load_level  in  1  one-cycle request to load level `level`.
- level  in  4  level number, sampled when load_level is accepted.
- player_dead  in  1  one-cycle pulse; re-arm all coins of the current level.
- rom_addr  out  AW  coin ROM address.
- rom_data  in  20  {x[19:10], y[9:0]} coin position, valid one cycle after rom_addr.
- collected  in  N_COINS  collected flag from each coin instance; bit i belongs to slot i.
- coin_x  out  10*N_COINS  packed x positions; slot i occupies [10i+9:10i].
- coin_y  out  10*N_COINS  packed y positions; same packing as coin_x.
- refresh  out  1  clears every coin's collected flag while high.
- busy  out  1  high in FETCH, CAPTURE and REARM.
- coins_total  out  $clog2(N_COINS+1)  number of non-empty slots in the loaded level.
- coins_left  out  $clog2(N_COINS+1)  non-empty slots not yet collected.
- all_collected  out  1  level-complete flag.

Behaviour:
- Reset values:
  - State IDLE; all coin_x/coin_y = 0.
  - refresh = 0, busy = 0, coins_total = 0, all_collected = 0.
  - rom_addr = 0, slot index = 0, latched level = 0.
- Empty slot: position (0,0). A coin reports collected=1 for an empty slot, so empty slots are excluded from every count.
- coins_left is combinational: the count of slots i where {coin_x_i, coin_y_i} != 0 and collected[i] == 0.
- IDLE: on load_level, latch the level, set idx = 0 and go to FETCH. The latched level is min(level, LEVELS-1). player_dead is ignored in IDLE.
- FETCH: rom_addr = lvl*N_COINS + idx; go to CAPTURE.
- CAPTURE:
  - Write rom_data into slot idx.
  - Increment coins_total if rom_data != 0; coins_total is zeroed on entry to the first FETCH of a load.
  - If idx == N_COINS-1, go to REARM; otherwise idx++ and return to FETCH.
  - A full load takes 2*N_COINS cycles in FETCH/CAPTURE.
- REARM: lasts exactly one cycle, then go to ACTIVE.
- refresh is registered. It is high in every cycle the FSM is in FETCH, CAPTURE or REARM, and low in IDLE and ACTIVE. Coins therefore never count a collection against a half-written position.
- ACTIVE:
  - Priority: load_level, then player_dead, then hold.
  - load_level: go to FETCH and reload; positions are overwritten slot by slot.
  - player_dead: go to REARM; positions are unchanged.
  - all_collected is registered. It is set the cycle after coins_left == 0 is observed in ACTIVE with coins_total != 0, and it stays set while in ACTIVE.
  - all_collected is cleared on any exit from ACTIVE.
- All states other than ACTIVE hold all_collected at 0.
- load_level and player_dead while busy are ignored; no queuing.
- Reset asserted mid-load: immediate return to reset values. Coins are then at (0,0), i.e. hidden.
- Level with all slots empty: coins_total = 0 and all_collected never asserts. The game FSM treats that level as coin-free.

Test Plan:
- Reset, then load_level with level=2 and ROM entries 8..11 = (100,50),(200,60),(300,70),(0,0).
  - Expect busy and refresh high for exactly 9 cycles (8 FETCH/CAPTURE + 1 REARM).
  - Then coin_x = {0,300,200,100}, coins_total = 3, coins_left = 3.
- After that load, drive collected = 4'b1001.
  - coins_left = 2 and all_collected = 0.
  - Then drive collected = 4'b1111: coins_left = 0 and all_collected = 1 one cycle later.
- In ACTIVE with collected = 4'b0011, pulse player_dead.
  - Expect refresh = 1 for one cycle and all_collected = 0.
  - Positions unchanged; no rom_addr activity.
- Assert load_level and player_dead in the same ACTIVE cycle.
  - Expect FETCH with rom_addr = new_level*4.
  - Expect no REARM-only path.
- Assert Reset during the third CAPTURE cycle.
  - All coin_x/coin_y = 0, refresh = 0 and state IDLE, asynchronously.
  - A later load_level completes normally.
- Request level=15 with LEVELS=8.
  - rom_addr sequence is 28, 29, 30, 31.
  - load_level pulses during busy are ignored.
